// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit code width and
// active-low a..g glyph patterns (bit 6 = a, bit 0 = g).
package seg_pkg;

    localparam int CODE_W = 4;

    typedef logic [CODE_W-1:0] code_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_glyph.sv
// Combinational digit-code to active-low glyph lookup. Without HEX_EN the
// codes 10..15 fall back to the "0" glyph.
module seg_glyph
    import seg_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (code)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = HEX_EN ? SEG_A : SEG_0;
            4'hB: seg = HEX_EN ? SEG_B : SEG_0;
            4'hC: seg = HEX_EN ? SEG_C : SEG_0;
            4'hD: seg = HEX_EN ? SEG_D : SEG_0;
            4'hE: seg = HEX_EN ? SEG_E : SEG_0;
            4'hF: seg = HEX_EN ? SEG_F : SEG_0;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: latches a packed digit word and scans
// it one digit per CLK_DIV cycles over an active-low segment bus and enables.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter bit HEX_EN  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CODE_W*DIGITS-1:0]   data,
    input  logic                       load,
    input  logic [DIGITS-1:0]          blank,
    input  logic                       zsup,
    output logic [6:0]                 out,
    output logic [DIGITS-1:0]          an
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [CODE_W*DIGITS-1:0] shadow;
    logic [PW-1:0]            presc;
    logic [IW-1:0]            idx;

    logic [DIGITS-1:0]        lead_zero;
    logic                     zrun;
    code_t                    dig_p0;
    logic                     blk_p0;
    logic [6:0]               glyph_p0;
    logic [DIGITS-1:0]        an_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Stage p0: a digit counts as leading zero when it and every digit above it are 0.
    always_comb begin
        zrun      = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zrun         = zrun && (shadow[CODE_W*i +: CODE_W] == '0);
            lead_zero[i] = zrun;
        end
    end

    always_comb begin
        dig_p0 = shadow[CODE_W*idx +: CODE_W];
        blk_p0 = blank[idx] | (zsup & (idx != '0) & lead_zero[idx]);
        an_p0  = blk_p0 ? '1 : ~(DIGITS'(1) << idx);
    end

    seg_glyph #(
        .HEX_EN (HEX_EN)
    ) u_glyph (
        .code (dig_p0),
        .seg  (glyph_p0)
    );

    // Stage p1: registered segment bus and digit enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= SEG_BLANK;
            an  <= '1;
        end else begin
            out <= blk_p0 ? SEG_BLANK : glyph_p0;
            an  <= an_p0;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a decimal and a hex instance share all
// inputs and are checked frame by frame against hand-written glyph tables.
module tb_seg_scan_driver;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0000100;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b1100000;
    localparam logic [6:0] GC = 7'b0110001;
    localparam logic [6:0] GF = 7'b0111000;
    localparam logic [6:0] GX = 7'b1111111;
    localparam logic [15:0] AN_SCAN = 16'b0111_1011_1101_1110;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        load;
    logic [3:0]  blank;
    logic        zsup;
    logic [6:0]  out, out_h;
    logic [3:0]  an, an_h;

    int vectors = 0;
    int miscompares = 0;

    seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .data(data), .load(load),
        .blank(blank), .zsup(zsup), .out(out), .an(an)
    );

    seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_EN(1'b1)) dut_hex (
        .clk(clk), .rst(rst), .data(data), .load(load),
        .blank(blank), .zsup(zsup), .out(out_h), .an(an_h)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] eo, input logic [6:0] eh,
                       input logic [3:0] ea);
        vectors++;
        assert (out === eo) else begin
            miscompares++;
            $error("FAIL %s out: got %b expected %b", tag, out, eo);
        end
        vectors++;
        assert (an === ea) else begin
            miscompares++;
            $error("FAIL %s an: got %b expected %b", tag, an, ea);
        end
        vectors++;
        assert (out_h === eh) else begin
            miscompares++;
            $error("FAIL %s hex out: got %b expected %b", tag, out_h, eh);
        end
        vectors++;
        assert (an_h === ea) else begin
            miscompares++;
            $error("FAIL %s hex an: got %b expected %b", tag, an_h, ea);
        end
    endtask

    // Runs one 16-edge frame from digit 0; an optional load is sampled on the
    // last edge so that it fills the following frame.
    task automatic frame(input string tag, input logic [27:0] exp_o, input logic [27:0] exp_h,
                         input logic [15:0] exp_a, input logic ld, input logic [15:0] ld_data);
        int d;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                load = ld;
                data = ld_data;
            end
            step();
            d = i / 4;
            chk($sformatf("%s d%0d c%0d", tag, d, i % 4),
                exp_o[d*7 +: 7], exp_h[d*7 +: 7], exp_a[d*4 +: 4]);
        end
        load = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        data  = 16'h0000;
        load  = 1'b0;
        blank = 4'b0000;
        zsup  = 1'b0;
        repeat (3) step();
        chk("reset hold", GX, GX, 4'b1111);

        rst = 1'b0;
        frame("zero", {G0, G0, G0, G0}, {G0, G0, G0, G0}, AN_SCAN, 1'b1, 16'h1234);
        frame("scan1234", {G1, G2, G3, G4}, {G1, G2, G3, G4}, AN_SCAN, 1'b1, 16'hABCF);
        frame("hexABCF", {G0, G0, G0, G0}, {GA, GB, GC, GF}, AN_SCAN, 1'b1, 16'h0040);

        zsup = 1'b1;
        frame("zsup_on", {GX, GX, G4, G0}, {GX, GX, G4, G0}, 16'b1111_1111_1101_1110,
              1'b0, 16'h0000);
        zsup = 1'b0;
        frame("zsup_off", {G0, G0, G4, G0}, {G0, G0, G4, G0}, AN_SCAN, 1'b1, 16'h8888);

        blank = 4'b0101;
        frame("blank", {G8, GX, G8, GX}, {G8, GX, G8, GX}, 16'b0111_1111_1101_1111,
              1'b0, 16'h0000);
        blank = 4'b0000;

        for (int i = 0; i < 4; i++) begin
            step();
            chk("midload d0", G8, G8, 4'b1110);
        end
        step();
        chk("midload d1 c0", G8, G8, 4'b1101);
        load = 1'b1;
        data = 16'h9999;
        step();
        chk("midload d1 c1", G8, G8, 4'b1101);
        load = 1'b0;
        step();
        chk("midload d1 c2", G9, G9, 4'b1101);
        step();
        chk("midload d1 c3", G9, G9, 4'b1101);
        step();
        chk("midload d2 c0", G9, G9, 4'b1011);
        step();
        chk("midload d2 c1", G9, G9, 4'b1011);

        rst = 1'b1;
        #1;
        chk("async reset", GX, GX, 4'b1111);
        step();
        chk("reset held", GX, GX, 4'b1111);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post reset d0", G0, G0, 4'b1110);
        end
        step();
        chk("post reset d1", G0, G0, 4'b1101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the dice board. Latches a packed BCD/hex word on a load strobe, scans it out one digit at a time over a shared active-low segment bus, and drives active-low digit enables. Supports decimal or hex glyphs, per-digit blanking and leading-zero suppression. Sits between the dice/score logic and the board's multi-digit display, replacing the single-digit registered decoder.

## Interface
- DIGITS, 4, number of display digits (1..8)
- CLK_DIV, 50000, clk cycles each digit stays enabled (≥2)
- HEX_EN, 0, 1 = codes 10..15 show A b C d E F; 0 = codes 10..15 show the "0" glyph

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- data  in  4*DIGITS  packed digit codes, digit i = data[4i+3:4i], digit 0 rightmost
- load  in  1  capture data into shadow register this edge
- blank  in  DIGITS  per-digit force-off mask, sampled live (not latched)
- zsup  in  1  leading-zero suppression enable, sampled live
- out  out  7  segment bus, active-low, out[6]=a … out[0]=g
- an  out  DIGITS  digit enables, active-low, one-hot-low while any digit is shown

## Operation
- Shadow register: 4*DIGITS bits; loaded from data on any edge with load=1; otherwise holds. Scan always reads shadow, never data directly.
- Prescaler: counts 0..CLK_DIV-1, wraps to 0; terminal count advances digit index.
- Digit index: 0..DIGITS-1, increments on prescaler terminal count, wraps DIGITS-1 → 0.
- Glyphs (active-low a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; hex A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; blank=1111111.
- Digit i is blanked if blank[i]=1, or zsup=1 and i>0 and every shadow digit from DIGITS-1 down to i is 0. Digit 0 is never zero-suppressed.
- Blanked digit: out=1111111 and an[i]=1 (all an bits high).
- Non-blanked digit: out=glyph(shadow digit index), an = all ones except an[index]=0.

## Timing
- Reset (async, immediate): shadow=0, prescaler=0, index=0, out=1111111, an=all ones. Reset asserted mid-scan aborts scan in the same instant.
- out and an are registered: they reflect index/shadow/blank/zsup as of the previous edge (1-cycle latency).
- First edge after rst deasserts: out/an show digit 0; index advances after CLK_DIV cycles; each digit occupies exactly CLK_DIV consecutive cycles of out/an; full frame = DIGITS*CLK_DIV cycles.
- load on edge N: shadow updated at N; out shows new value at edge N+1 for the current index (mid-digit update permitted, no frame alignment).
- load held high: shadow tracks data every cycle.
- load coincident with prescaler wrap: both take effect; edge N+1 shows new data on new index.
- DIGITS=1: index fixed at 0, an[0]=0 continuously unless blanked.

## Structure
- Package seg_pkg: 7-bit glyph constants SEG_0..SEG_F, SEG_BLANK; digit-code width constant (4).
- Sub-module seg_glyph: combinational code→glyph lookup with HEX_EN parameter; instantiated once on the muxed digit.
- Top holds shadow register, prescaler, index counter, suppression/blank logic and output registers.

## Test plan
- Reset: assert rst mid-frame → out=1111111, an=1111 immediately; release → next edge out=glyph(shadow[3:0]=0)=0000001, an=1110.
- Scan, DIGITS=4, CLK_DIV=4: load 16'h1234 → an cycles 1110,1101,1011,0111 each 4 cycles; out = 1001100, 0000110, 0010010, 1001111.
- Hex mode: HEX_EN=1, load 16'hABCF → d0=0111000, d3=0001000; same with HEX_EN=0 → d0..d3 all 0000001.
- Zero suppression: load 16'h0040, zsup=1 → d3,d2 blank (out=1111111, an=1111), d1=1001100, d0=0000001; zsup=0 → d3,d2 show 0000001.
- Blank mask: blank=4'b0101, shadow 16'h8888 → d0,d2 blank, d1,d3 out=0000000 with an=1101/0111.
- Mid-scan load: load 16'h9999 at cycle 2 of digit 1 → out changes to 0000100 next edge, index and prescaler unaffected.
